// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Summary  : Shared UART constants, rx state encoding and baud divider helper.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 7;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Rounded CLK_HZ / (BAUD * OVERSAMPLE), evaluated at elaboration.
    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Summary  : Free-running 0..DIV-1 divider with one-cycle tick and sync clear.
// Revision : 1.0
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (cnt_q == C_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_7n.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_7n
// Summary  : 7N1 oversampling UART receiver with one-deep valid/ready buffer.
//            UART_RX_MAJORITY_EN selects 2-of-3 majority bit sampling.
// Revision : 1.0
// ============================================================================
module uart_rx_7n
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50142857,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] C_HALF_LAST = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] C_FULL_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [2:0]     C_LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 sync1_q, rx_s_q, rx_q;
    rx_state_e            state_q, state_d;
    logic [SCW-1:0]       scnt_q, scnt_d;
    logic [2:0]           bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 tick, tick_clear, sample;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (tick_clear),
        .tick_o  (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    // Holds rx_s at the two previous ticks; the vote closes on the nominal tick.
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else if (tick) begin
            hist_q <= {hist_q[0], rx_s_q};
        end
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
    assign sample = rx_s_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_q    <= 1'b1;
            state_q <= RX_IDLE;
            scnt_q  <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
            rx_q    <= rx_s_q;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        bidx_d     = bidx_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = valid_q && !ready_i;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        tick_clear = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (rx_q && !rx_s_q) begin
                    state_d    = RX_START;
                    scnt_d     = '0;
                    tick_clear = 1'b1;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (scnt_q == C_HALF_LAST) begin
                        if (sample) begin
                            state_d = RX_IDLE;
                        end else begin
                            state_d = RX_DATA;
                            scnt_d  = '0;
                            bidx_d  = '0;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (scnt_q == C_FULL_LAST) begin
                        shreg_d = {sample, shreg_q[DATA_BITS-1:1]};
                        scnt_d  = '0;
                        if (bidx_q == C_LAST_BIT) begin
                            state_d = RX_STOP;
                        end else begin
                            bidx_d = bidx_q + 1'b1;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (scnt_q == C_FULL_LAST) begin
                        state_d = RX_IDLE;
                        if (!sample) begin
                            ferr_d = 1'b1;
                        end else if (!valid_q || ready_i) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != RX_IDLE);

endmodule
`default_nettype wire
